// File: rtl/spi_reg_decoder_if.sv
// Register-bus bundle between spi_reg_decoder (master) and the peripheral register file (slave).
interface spi_reg_decoder_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
);
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_write;
    logic [DATA_W-1:0] data_read;

    modport master (
        output read,
        output write,
        output addr,
        output data_write,
        input  data_read
    );

    modport slave (
        input  read,
        input  write,
        input  addr,
        input  data_write,
        output data_read
    );
endinterface

// File: rtl/spi_reg_decoder.sv
// SPI mode-0 slave decoding 2-byte command/data frames into single-cycle register-bus strobes.
// Optional multi-byte bursts with address auto-increment: define SPI_AUTO_INC_EN.
module spi_reg_decoder #(
    parameter int ADDR_W      = 6,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              busy,
    spi_reg_decoder_if.master bus
);

    localparam int CNT_W = $clog2(2 * DATA_W);
    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] DATA_FIRST = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(2 * DATA_W - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CMD  = 2'd1;
    localparam logic [1:0] DATA = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] sync_valid;
    logic                   sclk_s;
    logic                   cs_s;
    logic                   mosi_s;
    logic                   sclk_prev;
    logic                   sclk_rise;
    logic                   sclk_fall;

    logic [1:0]             state;
    logic [CNT_W-1:0]       cnt;
    logic [DATA_W-2:0]      rx_sr;
    logic [DATA_W-1:0]      rx_next;
    logic [DATA_W-1:0]      tx_sr;
    logic                   is_write;
    logic                   armed;
    logic                   read_q;
    logic                   write_q;
    logic [ADDR_W-1:0]      addr_q;
    logic [DATA_W-1:0]      data_write_q;
`ifdef SPI_AUTO_INC_EN
    logic                   inc_pending;
`endif

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign rx_next   = {rx_sr, mosi_s};

    assign miso           = tx_sr[DATA_W-1];
    assign bus.read       = read_q;
    assign bus.write      = write_q;
    assign bus.addr       = addr_q;
    assign bus.data_write = data_write_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_sync  <= '0;
            cs_sync    <= '1;
            mosi_sync  <= '0;
            sync_valid <= '0;
            sclk_prev  <= 1'b0;
        end else begin
            sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync    <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            mosi_sync  <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sync_valid <= {sync_valid[SYNC_STAGES-2:0], 1'b1};
            sclk_prev  <= sclk_s;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            rx_sr        <= '0;
            tx_sr        <= '0;
            is_write     <= 1'b0;
            armed        <= 1'b0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            data_write_q <= '0;
            busy         <= 1'b0;
`ifdef SPI_AUTO_INC_EN
            inc_pending  <= 1'b0;
`endif
        end else begin
            read_q  <= 1'b0;
            write_q <= 1'b0;

            // Synchroniser resets to cs_n=1, so only trust a high level once the chain holds real samples;
            // a cs_n held low through reset therefore cannot start a frame.
            if (sync_valid[SYNC_STAGES-1] && cs_s)
                armed <= 1'b1;

            if (read_q)
                tx_sr <= bus.data_read;

            case (state)
                IDLE: begin
                    if (armed && !cs_s) begin
                        state <= CMD;
                        busy  <= 1'b1;
                        cnt   <= '0;
                    end
                end
                default: begin
                    if (cs_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                        tx_sr <= '0;
`ifdef SPI_AUTO_INC_EN
                        inc_pending <= 1'b0;
`endif
                    end else if (state != DONE) begin
                        if (sclk_rise) begin
                            rx_sr <= rx_next[DATA_W-2:0];
                            cnt   <= cnt + CNT_W'(1);
                            if (state == CMD && cnt == CMD_LAST) begin
                                state    <= DATA;
                                addr_q   <= rx_next[ADDR_W-1:0];
                                is_write <= rx_next[DATA_W-1];
                                read_q   <= ~rx_next[DATA_W-1];
                            end else if (state == DATA && cnt == DATA_LAST) begin
                                if (is_write) begin
                                    write_q      <= 1'b1;
                                    data_write_q <= rx_next;
                                end
`ifdef SPI_AUTO_INC_EN
                                // Stay in DATA; reads pre-fetch the next address so miso has no gap.
                                cnt <= DATA_FIRST;
                                if (is_write) begin
                                    inc_pending <= 1'b1;
                                end else begin
                                    addr_q <= addr_q + ADDR_W'(1);
                                    read_q <= 1'b1;
                                end
`else
                                state <= DONE;
                                tx_sr <= '0;
`endif
                            end
`ifdef SPI_AUTO_INC_EN
                            else if (state == DATA && inc_pending) begin
                                addr_q      <= addr_q + ADDR_W'(1);
                                inc_pending <= 1'b0;
                            end
`endif
                        end else if (sclk_fall && state == DATA && cnt > DATA_FIRST) begin
                            // The fall right after a byte boundary keeps the freshly loaded MSB on miso.
                            tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_reg_decoder.sv
// Directed bench for spi_reg_decoder: bus strobes are scoreboarded, miso and status checked inline.
module tb_spi_reg_decoder;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic sclk  = 1'b0;
    logic cs_n  = 1'b1;
    logic mosi  = 1'b0;
    logic miso;
    logic busy;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    logic [7:0]  rd_val = 8'h00;
    int unsigned rd_age = 2;

    typedef struct {
        bit         is_write;
        logic [5:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t cur;

    spi_reg_decoder_if #(.ADDR_W(6), .DATA_W(8)) bus_if ();

    // Read data is only valid in the clk right after the strobe; it is inverted otherwise.
    assign bus_if.data_read = (rd_age >= 2) ? ~rd_val : rd_val;

    spi_reg_decoder #(.ADDR_W(6), .DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sclk  (sclk),
        .cs_n  (cs_n),
        .mosi  (mosi),
        .miso  (miso),
        .busy  (busy),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input bit w, input logic [5:0] a, input logic [7:0] d);
        sb.push_back('{w, a, d});
    endtask

    always @(negedge clk) begin
        if (bus_if.read || bus_if.write) begin
            if (sb.size() == 0) begin
                check("unexpected_strobe", 32'({bus_if.read, bus_if.write}), 32'd0);
            end else begin
                cur = sb.pop_front();
                check("strobe_kind", 32'({bus_if.write, bus_if.read}), cur.is_write ? 32'd2 : 32'd1);
                check("strobe_addr", 32'(bus_if.addr), 32'(cur.addr));
                if (cur.is_write)
                    check("strobe_data", 32'(bus_if.data_write), 32'(cur.data));
            end
        end
        if (bus_if.read)
            rd_age = 1;
        else if (rd_age < 2)
            rd_age++;
    end

    task automatic spi_xfer(input logic [23:0] tx, input int unsigned nbits, input int unsigned h,
                            input logic [7:0] miso_exp, input bit miso_chk);
        cs_n = 1'b0;
        repeat (h) @(negedge clk);
        for (int unsigned b = 0; b < nbits; b++) begin
            mosi = tx[23 - b];
            repeat (h) @(negedge clk);
            sclk = 1'b1;
            repeat (h) @(negedge clk);
            if (miso_chk && b >= 8 && b < 16)
                check("miso_bit", 32'(miso), 32'(miso_exp[15 - b]));
            sclk = 1'b0;
        end
        mosi = 1'b0;
    endtask

    task automatic cs_release(input int unsigned gap);
        cs_n = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_read"},  32'(bus_if.read), 32'd0);
        check({tag, "_write"}, 32'(bus_if.write), 32'd0);
        check({tag, "_miso"},  32'(miso), 32'd0);
        check({tag, "_busy"},  32'(busy), 32'd0);
    endtask

    initial begin
        #500us;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (5) @(negedge clk);
        check_idle_outputs("reset");
        check("reset_addr", 32'(bus_if.addr), 32'd0);
        check("reset_data_write", 32'(bus_if.data_write), 32'd0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        // Write 0x83, 0xA5
        push_exp(1'b1, 6'h03, 8'hA5);
        spi_xfer(24'h83A500, 16, 4, 8'h00, 1'b1);
        check("wr_busy_during", 32'(busy), 32'd1);
        cs_release(8);
        check("wr_addr", 32'(bus_if.addr), 32'h03);
        check("wr_data", 32'(bus_if.data_write), 32'hA5);
        check("wr_busy_after", 32'(busy), 32'd0);

        // Read addr 0x0A returning 0x5C, data_read changes after capture
        rd_val = 8'h5C;
        push_exp(1'b0, 6'h0A, 8'h00);
`ifdef SPI_AUTO_INC_EN
        push_exp(1'b0, 6'h0B, 8'h00);
`endif
        spi_xfer(24'h0A0000, 16, 4, 8'h5C, 1'b1);
        repeat (4) @(negedge clk);
`ifndef SPI_AUTO_INC_EN
        check("rd_miso_done", 32'(miso), 32'd0);
`endif
        cs_release(8);
        check("rd_miso_idle", 32'(miso), 32'd0);
        check("rd_busy_after", 32'(busy), 32'd0);

        // Abort a write after 12 bits
        spi_xfer(24'h85FF00, 12, 4, 8'h00, 1'b0);
        cs_release(8);
        check("abort_data_kept", 32'(bus_if.data_write), 32'hA5);
        check("abort_addr", 32'(bus_if.addr), 32'h05);
        check("abort_busy", 32'(busy), 32'd0);

        // Reset after 10 bits, cs_n still low through and after reset
        spi_xfer(24'h812200, 10, 4, 8'h00, 1'b0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("midrst");
        check("midrst_addr", 32'(bus_if.addr), 32'd0);
        check("midrst_data_write", 32'(bus_if.data_write), 32'd0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("midrst_no_restart", 32'(busy), 32'd0);
        cs_release(8);
        push_exp(1'b1, 6'h00, 8'h11);
        spi_xfer(24'h801100, 16, 4, 8'h00, 1'b1);
        cs_release(8);
        check("post_rst_data", 32'(bus_if.data_write), 32'h11);

        // Burst write 0xBF, 0x01, 0x02
        push_exp(1'b1, 6'h3F, 8'h01);
`ifdef SPI_AUTO_INC_EN
        push_exp(1'b1, 6'h00, 8'h02);
`endif
        spi_xfer(24'hBF0102, 24, 4, 8'h00, 1'b1);
        cs_release(8);
`ifdef SPI_AUTO_INC_EN
        check("burst_addr", 32'(bus_if.addr), 32'h00);
        check("burst_data", 32'(bus_if.data_write), 32'h02);
`else
        check("burst_addr", 32'(bus_if.addr), 32'h3F);
        check("burst_data", 32'(bus_if.data_write), 32'h01);
`endif

        // clk = 4*sclk, back-to-back frames with one sclk period of cs_n high; 0xD0 has reserved bit set
        push_exp(1'b1, 6'h10, 8'h3C);
        spi_xfer(24'hD03C00, 16, 2, 8'h00, 1'b0);
        cs_release(4);
        push_exp(1'b1, 6'h21, 8'hC3);
        spi_xfer(24'hA1C300, 16, 2, 8'h00, 1'b0);
        cs_release(4);
        push_exp(1'b1, 6'h0E, 8'h7E);
        spi_xfer(24'h8E7E00, 16, 2, 8'h00, 1'b0);
        cs_release(8);
        check("ratio_addr", 32'(bus_if.addr), 32'h0E);
        check("ratio_data", 32'(bus_if.data_write), 32'h7E);

        // sclk toggling with cs_n high must be ignored
        for (int i = 0; i < 8; i++) begin
            mosi = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
        mosi = 1'b0;
        repeat (8) @(negedge clk);
        check("cs_high_busy", 32'(busy), 32'd0);
        check("cs_high_addr", 32'(bus_if.addr), 32'h0E);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
